// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline.
// Holds the word-addressed data RAM and a wait-state FSM that stalls upstream
// during slow loads and stores. It also resolves branches and holds the MEM/WB
// register that feeds writeback.
//
// Handshake: there is no valid/ready pair here. stall is the only flow control.
// While stall=1, upstream freezes the EX/MEM inputs. The access completes in
// the first cycle that a mem op is present with stall=0. Only that cycle's
// edge writes RAM or captures real controls into MEM/WB. Every stalled edge
// captures a bubble instead.
module mem_stage #(
   parameter int ADDR_W   = 8,
   parameter int WAIT_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        regwr,
   input  logic        memreg,
   input  logic        memwr,
   input  logic        memrd,
   input  logic        br,
   input  logic        zr,
   input  logic [31:0] npc,
   input  logic [31:0] aluout,
   input  logic [31:0] reg2,
   input  logic [4:0]  ir5bit,
   output logic        pcsrc,
   output logic [31:0] brtarget,
   output logic        stall,
   output logic        maerr,
   output logic        regwro,
   output logic        memrego,
   output logic [31:0] rdatao,
   output logic [31:0] aluouto,
   output logic [4:0]  ir5bito
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  cnt_dec;
   logic        complete;
   logic        bubble;

   logic        regwr_q, regwr_d;
   logic        memreg_q, memreg_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] alu_q, alu_d;
   logic [4:0]  ir5_q, ir5_d;
   logic        maerr_q, maerr_d;

   logic [31:0]       ram [0:(1 << ADDR_W) - 1];
   logic [ADDR_W-1:0] idx;
   logic              mem_op;
   logic              is_st;
   logic              is_ld;
   logic              misal;
   logic [31:0]       ram_rdata;
   logic              unused_addr_hi;

   // Upper address bits are dropped on purpose so that accesses wrap modulo the RAM depth.
   assign idx            = aluout[ADDR_W+1:2];
   assign unused_addr_hi = ^aluout[31:ADDR_W+2];
   assign mem_op         = memwr | memrd;
   assign is_st          = memwr;
   assign is_ld          = memrd & ~memwr;
   assign misal          = aluout[1:0] != 2'b00;
   assign ram_rdata      = ram[idx];
   assign cnt_dec        = cnt_q - 4'd1;

   // Branch resolution is pure combinational and independent of the FSM.
   assign pcsrc    = br & zr;
   assign brtarget = npc;

   // FSM state and wait counter register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, stall, and completion detect. In BUSY, the decremented count
   // decides whether this is the completing cycle. This makes the total latency WAIT_CYC+1.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall    = 1'b0;
      complete = 1'b0;
      bubble   = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               if (WAIT_CYC == 0) begin
                  complete = 1'b1;
               end else begin
                  stall   = 1'b1;
                  bubble  = 1'b1;
                  cnt_d   = 4'(WAIT_CYC);
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_dec;
            if (!mem_op) begin
               // The op vanished under a stall. Drop it, and never write.
               bubble  = 1'b1;
               cnt_d   = 4'd0;
               state_d = IDLE;
            end else if (cnt_dec != 4'd0) begin
               stall  = 1'b1;
               bubble = 1'b1;
            end else begin
               complete = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // MEM/WB next values. A bubble clears every field. A load returns data only when it is aligned and is not paired with a store.
   always_comb begin
      regwr_d  = regwr;
      memreg_d = memreg;
      alu_d    = aluout;
      ir5_d    = ir5bit;
      rdata_d  = 32'd0;
      maerr_d  = 1'b0;
      if (bubble) begin
         regwr_d  = 1'b0;
         memreg_d = 1'b0;
         alu_d    = 32'd0;
         ir5_d    = 5'd0;
      end else if (complete) begin
         if (is_ld && !misal) rdata_d = ram_rdata;
         maerr_d = misal;
      end
   end

   // MEM/WB register. maerr is latched together with the completing op, so it pulses for exactly one cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         regwr_q  <= 1'b0;
         memreg_q <= 1'b0;
         rdata_q  <= 32'd0;
         alu_q    <= 32'd0;
         ir5_q    <= 5'd0;
         maerr_q  <= 1'b0;
      end else begin
         regwr_q  <= regwr_d;
         memreg_q <= memreg_d;
         rdata_q  <= rdata_d;
         alu_q    <= alu_d;
         ir5_q    <= ir5_d;
         maerr_q  <= maerr_d;
      end
   end

   // RAM write. It happens only on the completing edge of an aligned store, and never during reset.
   always_ff @(posedge clk) begin
      if (rst && complete && is_st && !misal) ram[idx] <= reg2;
   end

   assign regwro  = regwr_q;
   assign memrego = memreg_q;
   assign rdatao  = rdata_q;
   assign aluouto = alu_q;
   assign ir5bito = ir5_q;
   assign maerr   = maerr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage.
// Instance u0 runs with WAIT_CYC=2 and instance u1 runs with WAIT_CYC=0; both
// share one input bus. The driver checks the combinational outputs and pushes
// the expected MEM/WB word for the coming edge. A separate monitor pops one
// entry after each edge and compares it.
module tb_mem_stage;

   localparam int W = 72;

   logic        clk;
   logic        rst;
   logic        regwr, memreg, memwr, memrd, br, zr;
   logic [31:0] npc, aluout, reg2;
   logic [4:0]  ir5bit;

   logic        pcsrc0, stall0, maerr0, regwro0, memrego0;
   logic [31:0] brtarget0, rdatao0, aluouto0;
   logic [4:0]  ir5bito0;
   logic        pcsrc1, stall1, maerr1, regwro1, memrego1;
   logic [31:0] brtarget1, rdatao1, aluouto1;
   logic [4:0]  ir5bito1;

   logic [W-1:0] exp0_q[$];
   logic [W-1:0] exp1_q[$];
   logic [W-1:0] e0, e1, a0, a1;
   int checks = 0;
   int passes = 0;

   mem_stage #(.ADDR_W(8), .WAIT_CYC(2)) u0 (
      .clk(clk), .rst(rst), .regwr(regwr), .memreg(memreg), .memwr(memwr),
      .memrd(memrd), .br(br), .zr(zr), .npc(npc), .aluout(aluout),
      .reg2(reg2), .ir5bit(ir5bit), .pcsrc(pcsrc0), .brtarget(brtarget0),
      .stall(stall0), .maerr(maerr0), .regwro(regwro0), .memrego(memrego0),
      .rdatao(rdatao0), .aluouto(aluouto0), .ir5bito(ir5bito0)
   );

   mem_stage #(.ADDR_W(8), .WAIT_CYC(0)) u1 (
      .clk(clk), .rst(rst), .regwr(regwr), .memreg(memreg), .memwr(memwr),
      .memrd(memrd), .br(br), .zr(zr), .npc(npc), .aluout(aluout),
      .reg2(reg2), .ir5bit(ir5bit), .pcsrc(pcsrc1), .brtarget(brtarget1),
      .stall(stall1), .maerr(maerr1), .regwro(regwro1), .memrego(memrego1),
      .rdatao(rdatao1), .aluouto(aluouto1), .ir5bito(ir5bito1)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] pk(input logic rw, input logic mr,
                                       input logic [31:0] rd, input logic [31:0] ao,
                                       input logic [4:0] ir, input logic me);
      return {rw, mr, rd, ao, ir, me};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      else passes++;
   endtask

   task automatic apply(input logic r_n, input logic rw, input logic mr,
                        input logic mw, input logic md, input logic b, input logic z,
                        input logic [31:0] np, input logic [31:0] ao,
                        input logic [31:0] r2, input logic [4:0] ir);
      @(negedge clk);
      rst = r_n; regwr = rw; memreg = mr; memwr = mw; memrd = md;
      br = b; zr = z; npc = np; aluout = ao; reg2 = r2; ir5bit = ir;
   endtask

   // One instruction on u0. A mem op takes WAIT_CYC+1 cycles, and the stalled cycles expect bubbles.
   task automatic op0(input string nm, input logic rw, input logic mr,
                      input logic mw, input logic md, input logic [31:0] ao,
                      input logic [31:0] r2, input logic [4:0] ir,
                      input logic [31:0] rd_exp, input logic me_exp);
      int n;
      n = (mw | md) ? 2 : 0;
      for (int c = 0; c <= n; c++) begin
         apply(1'b1, rw, mr, mw, md, 1'b0, 1'b0, 32'd0, ao, r2, ir);
         #1;
         chk({nm, "_stall"}, {31'd0, stall0}, {31'd0, (c < n)});
         if (c < n) exp0_q.push_back('0);
         else       exp0_q.push_back(pk(rw, mr, rd_exp, ao, ir, me_exp));
      end
   endtask

   // One instruction on u1. It must never stall.
   task automatic op1(input string nm, input logic rw, input logic mr,
                      input logic mw, input logic md, input logic [31:0] ao,
                      input logic [31:0] r2, input logic [4:0] ir,
                      input logic [31:0] rd_exp);
      apply(1'b1, rw, mr, mw, md, 1'b0, 1'b0, 32'd0, ao, r2, ir);
      #1;
      chk({nm, "_stall"}, {31'd0, stall1}, 32'd0);
      exp1_q.push_back(pk(rw, mr, rd_exp, ao, ir, 1'b0));
   endtask

   task automatic branch0(input string nm, input logic z, input logic [31:0] np,
                          input logic pc_exp);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, z, np, 32'd0, 32'd0, 5'd0);
      #1;
      chk({nm, "_pcsrc"}, {31'd0, pcsrc0}, {31'd0, pc_exp});
      chk({nm, "_brtarget"}, brtarget0, np);
      chk({nm, "_stall"}, {31'd0, stall0}, 32'd0);
      exp0_q.push_back('0);
   endtask

   // Monitor for u0: after each edge, compare the MEM/WB fields and maerr.
   always @(posedge clk) begin
      #1;
      if (exp0_q.size() > 0) begin
         e0 = exp0_q.pop_front();
         a0 = {regwro0, memrego0, rdatao0, aluouto0, ir5bito0, maerr0};
         checks++;
         if (a0 !== e0) $display("FAIL mwb0 actual=%h expected=%h", a0, e0);
         else passes++;
      end
   end

   // Monitor for u1
   always @(posedge clk) begin
      #1;
      if (exp1_q.size() > 0) begin
         e1 = exp1_q.pop_front();
         a1 = {regwro1, memrego1, rdatao1, aluouto1, ir5bito1, maerr1};
         checks++;
         if (a1 !== e1) $display("FAIL mwb1 actual=%h expected=%h", a1, e1);
         else passes++;
      end
   end

   initial begin
      rst = 1'b0; regwr = 0; memreg = 0; memwr = 0; memrd = 0; br = 0; zr = 0;
      npc = 0; aluout = 0; reg2 = 0; ir5bit = 0;

      // Reset: all MEM/WB outputs and maerr are zero.
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0);
         exp0_q.push_back('0);
      end

      op0("alu", 1, 0, 0, 0, 32'h1234, 32'd0, 5'd7, 32'd0, 0);
      branch0("br_taken", 1'b1, 32'h40, 1'b1);
      branch0("br_not", 1'b0, 32'h80, 1'b0);
      op0("sw10", 0, 0, 1, 0, 32'h10, 32'hDEADBEEF, 5'd0, 32'd0, 0);
      op0("lw10", 1, 1, 0, 1, 32'h10, 32'd0, 5'd9, 32'hDEADBEEF, 0);
      op0("sw13", 0, 0, 1, 0, 32'h13, 32'h55555555, 5'd0, 32'd0, 1);
      op0("lw13", 1, 1, 0, 1, 32'h13, 32'd0, 5'd3, 32'd0, 1);
      op0("lw10b", 1, 1, 0, 1, 32'h10, 32'd0, 5'd4, 32'hDEADBEEF, 0);
      op0("both30", 1, 1, 1, 1, 32'h30, 32'h77, 5'd2, 32'd0, 0);
      op0("lw30", 1, 1, 0, 1, 32'h30, 32'd0, 5'd5, 32'h77, 0);
      op0("sw20", 0, 0, 1, 0, 32'h20, 32'hAAAA5555, 5'd0, 32'd0, 0);

      // The store enters BUSY, then reset hits on its second cycle. No write may occur.
      apply(1'b1, 0, 0, 1, 0, 0, 0, 32'd0, 32'h20, 32'h12345678, 5'd0);
      #1 chk("abort_c1_stall", {31'd0, stall0}, 32'd1);
      exp0_q.push_back('0);
      apply(1'b0, 0, 0, 1, 0, 0, 0, 32'd0, 32'h20, 32'h12345678, 5'd0);
      #1 chk("abort_c2_stall", {31'd0, stall0}, 32'd1);
      exp0_q.push_back('0);
      apply(1'b1, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0);
      #1 chk("abort_after_stall", {31'd0, stall0}, 32'd0);
      exp0_q.push_back('0);
      op0("lw20", 1, 1, 0, 1, 32'h20, 32'd0, 5'd6, 32'hAAAA5555, 0);

      // WAIT_CYC=0 instance: single-cycle accesses, with address wrap.
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0);
         exp1_q.push_back('0);
      end
      op1("w0_sw400", 0, 0, 1, 0, 32'h400, 32'hCAFE0001, 5'd0, 32'd0);
      op1("w0_lw0", 1, 1, 0, 1, 32'h0, 32'd0, 5'd1, 32'hCAFE0001);
      op1("w0_sw4", 0, 0, 1, 0, 32'h4, 32'h0BADF00D, 5'd0, 32'd0);
      op1("w0_lw404", 1, 1, 0, 1, 32'h404, 32'd0, 5'd2, 32'h0BADF00D);
      op1("w0_lw400", 1, 1, 0, 1, 32'h400, 32'd0, 5'd3, 32'hCAFE0001);
      op1("w0_alu", 1, 0, 0, 0, 32'h55, 32'd0, 5'd8, 32'd0);

      apply(1'b1, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0);
      // Bounded drain of any outstanding expectations.
      for (int i = 0; i < 5 && (exp0_q.size() + exp1_q.size()) > 0; i++) @(negedge clk);
      if ((exp0_q.size() + exp1_q.size()) > 0) begin
         checks++;
         $display("FAIL drain actual=%0d expected=0", exp0_q.size() + exp1_q.size());
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
